// File: rtl/amax10_qsys_nios2_gen2_oci_dct_ctrl.sv
// amax10_qsys_nios2_gen2_oci_dct_ctrl
// Packs variable-width bursts of 2-bit trace atoms into 32-bit trace-RAM words.
// A session runs from arm to test_ending. The residual partial word is flushed
// zero-padded, then test_has_ended is raised.
//
// Ports:
//   clk, reset             sole clock, synchronous active-high reset
//   arm                    pulse, starts a capture session
//   dct_valid/buffer/count up to 15 packed atoms per cycle, atom 0 in [1:0]
//   test_ending            pulse, ends the session and requests a flush
//   tw_we/tw_addr/tw_data  registered trace-RAM write port
//   busy                   high in CAPTURE or FLUSH
//   tw_full, wrapped       sticky RAM-full / pointer-wrapped flags
//   atoms_lost             sticky, a word was discarded while full
//   test_has_ended         level, session complete and flushed
//
// Configuration macro: TRACE_WRAP_EN
//   defined   -> the write pointer wraps to 0 and sets wrapped
//   undefined -> writes stop at the last address and set tw_full
module amax10_qsys_nios2_gen2_oci_dct_ctrl #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              dct_valid,
    input  logic [29:0]       dct_buffer,
    input  logic [3:0]        dct_count,
    input  logic              test_ending,
    output logic              tw_we,
    output logic [ADDR_W-1:0] tw_addr,
    output logic [31:0]       tw_data,
    output logic              busy,
    output logic              tw_full,
    output logic              wrapped,
    output logic              atoms_lost,
    output logic              test_has_ended
);

    localparam int unsigned ACC_W  = 62;
    localparam int unsigned FILL_W = 5;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORD_ATOMS = 16;

    typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    logic                we_d, busy_d, full_d, wrapped_d, lost_d, ended_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [WORD_W-1:0]   data_d;

    logic [ACC_W-1:0]    atom_mask, new_atoms, merged;
    logic [FILL_W-1:0]   merged_fill;
    logic                emit;
    logic [WORD_W-1:0]   emit_word;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            fill_q         <= '0;
            wp_q           <= '0;
            tw_we          <= 1'b0;
            tw_addr        <= '0;
            tw_data        <= '0;
            busy           <= 1'b0;
            tw_full        <= 1'b0;
            wrapped        <= 1'b0;
            atoms_lost     <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            fill_q         <= fill_d;
            wp_q           <= wp_d;
            tw_we          <= we_d;
            tw_addr        <= addr_d;
            tw_data        <= data_d;
            busy           <= busy_d;
            tw_full        <= full_d;
            wrapped        <= wrapped_d;
            atoms_lost     <= lost_d;
            test_has_ended <= ended_d;
        end
    end

    // Next-state, accumulator and write-port logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        wp_d      = wp_q;
        we_d      = 1'b0;
        addr_d    = tw_addr;
        data_d    = tw_data;
        full_d    = tw_full;
        wrapped_d = wrapped;
        lost_d    = atoms_lost;
        ended_d   = test_has_ended;
        emit      = 1'b0;
        emit_word = '0;

        // New atoms are masked to dct_count and placed just above the current fill;
        // bits above the fill level are kept zero so residual words pad with zeros.
        atom_mask   = (ACC_W'(1) << {dct_count, 1'b0}) - ACC_W'(1);
        new_atoms   = dct_valid ? ((ACC_W'(dct_buffer) & atom_mask) << {fill_q, 1'b0}) : '0;
        merged      = acc_q | new_atoms;
        merged_fill = dct_valid ? (fill_q + FILL_W'(dct_count)) : fill_q;

        case (state_q)
            IDLE, DONE: begin
                if (arm) begin
                    state_d   = CAPTURE;
                    acc_d     = '0;
                    fill_d    = '0;
                    wp_d      = '0;
                    addr_d    = '0;
                    full_d    = 1'b0;
                    wrapped_d = 1'b0;
                    lost_d    = 1'b0;
                    ended_d   = 1'b0;
                end else if (state_q == IDLE && test_ending) begin
                    state_d = DONE;
                    ended_d = 1'b1;
                end
            end
            CAPTURE: begin
                // Fill before merge is at most 15, so the merged fill never exceeds 30.
                if (merged_fill >= FILL_W'(WORD_ATOMS)) begin
                    emit      = 1'b1;
                    emit_word = merged[WORD_W-1:0];
                    acc_d     = merged >> WORD_W;
                    fill_d    = merged_fill - FILL_W'(WORD_ATOMS);
                end else begin
                    acc_d  = merged;
                    fill_d = merged_fill;
                end
                if (test_ending) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fill_q >= FILL_W'(WORD_ATOMS)) begin
                    emit      = 1'b1;
                    emit_word = acc_q[WORD_W-1:0];
                    acc_d     = acc_q >> WORD_W;
                    fill_d    = fill_q - FILL_W'(WORD_ATOMS);
                end else if (fill_q != '0) begin
                    emit      = 1'b1;
                    emit_word = acc_q[WORD_W-1:0];
                    acc_d     = '0;
                    fill_d    = '0;
                end else begin
                    state_d = DONE;
                    ended_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Word issue: write and advance the pointer, or drop it once full
        if (emit) begin
            if (tw_full) begin
                lost_d = 1'b1;
            end else begin
                we_d   = 1'b1;
                data_d = emit_word;
                addr_d = wp_q;
                wp_d   = wp_q + ADDR_W'(1);
                if (wp_q == {ADDR_W{1'b1}}) begin
`ifdef TRACE_WRAP_EN
                    wrapped_d = 1'b1;
`else
                    full_d = 1'b1;
`endif
                end
            end
        end

        busy_d = (state_d == CAPTURE) || (state_d == FLUSH);
    end

endmodule

// File: tb/tb_amax10_qsys_nios2_gen2_oci_dct_ctrl.sv
// Scoreboard bench: stimulus pushes expected writes (address, data, cycle) into
// queues; a negedge monitor pops and compares every tw_we it observes.
// Two instances share stimulus: ADDR_W=8 for the main cases, ADDR_W=2 for full/wrap.
module tb_amax10_qsys_nios2_gen2_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;

    logic        we_b, busy_b, full_b, wrapped_b, lost_b, ended_b;
    logic [7:0]  addr_b;
    logic [31:0] data_b;
    logic        we_s, busy_s, full_s, wrapped_s, lost_s, ended_s;
    logic [1:0]  addr_s;
    logic [31:0] data_s;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_b[$];
    exp_t        exp_s[$];
    exp_t        eb;
    exp_t        es;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cyc = '0;
    bit          mon_s_en = 1'b0;

    amax10_qsys_nios2_gen2_oci_dct_ctrl #(.ADDR_W(8)) dut_b (
        .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .tw_we(we_b), .tw_addr(addr_b), .tw_data(data_b), .busy(busy_b),
        .tw_full(full_b), .wrapped(wrapped_b), .atoms_lost(lost_b),
        .test_has_ended(ended_b)
    );

    amax10_qsys_nios2_gen2_oci_dct_ctrl #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .tw_we(we_s), .tw_addr(addr_s), .tw_data(data_s), .busy(busy_s),
        .tw_full(full_s), .wrapped(wrapped_s), .atoms_lost(lost_s),
        .test_has_ended(ended_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every observed write must match the head of its queue
    always @(negedge clk) begin
        if (we_b) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_write: got addr %0h data %0h expected no write", addr_b, data_b);
            end else begin
                eb = exp_b.pop_front();
                check("b_addr", 64'(addr_b), 64'(eb.addr));
                check("b_data", 64'(data_b), 64'(eb.data));
                check("b_cycle", 64'(cyc), 64'(eb.cyc));
            end
        end
        if (mon_s_en && we_s) begin
            if (exp_s.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL s_unexpected_write: got addr %0h data %0h expected no write", addr_s, data_s);
            end else begin
                es = exp_s.pop_front();
                check("s_addr", 64'({6'b0, addr_s}), 64'(es.addr));
                check("s_data", 64'(data_s), 64'(es.data));
                check("s_cycle", 64'(cyc), 64'(es.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [7:0] a, input logic [31:0] d, input logic [31:0] c);
        exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        exp_b.push_back(e);
    endtask

    task automatic push_s(input logic [7:0] a, input logic [31:0] d, input logic [31:0] c);
        exp_t e;
        e.addr = a; e.data = d; e.cyc = c;
        exp_s.push_back(e);
    endtask

    // Present one cycle of inputs, then return to quiet values
    task automatic present(input logic a, input logic v, input logic [3:0] cnt,
                           input logic [29:0] bufv, input logic te);
        arm = a; dct_valid = v; dct_count = cnt; dct_buffer = bufv; test_ending = te;
        tick();
        arm = 1'b0; dct_valid = 1'b0; dct_count = 4'd0; dct_buffer = 30'd0; test_ending = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (exp_b.size() != 0 || exp_s.size() != 0); i++) tick();
        check("queues_drained", 64'(exp_b.size() + exp_s.size()), 64'd0);
    endtask

    task automatic end_session();
        int k;
        present(1'b0, 1'b0, 4'd0, 30'd0, 1'b1);
        k = 0;
        while (!ended_b && k < 3) begin
            tick();
            k++;
        end
        check("session_ended", 64'(ended_b), 64'd1);
        check("busy_after_end", 64'(busy_b), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},     64'(we_b),      64'd0);
        check({tag, "_addr"},   64'(addr_b),    64'd0);
        check({tag, "_data"},   64'(data_b),    64'd0);
        check({tag, "_busy"},   64'(busy_b),    64'd0);
        check({tag, "_full"},   64'(full_b),    64'd0);
        check({tag, "_wrap"},   64'(wrapped_b), 64'd0);
        check({tag, "_lost"},   64'(lost_b),    64'd0);
        check({tag, "_ended"},  64'(ended_b),   64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1; arm = 1'b0; dct_valid = 1'b0; dct_buffer = 30'd0;
        dct_count = 4'd0; test_ending = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        // Two cycles of 8 atoms 01 -> one word 0x5555_5555 at addr 0; upper atoms are garbage
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        check("busy_capture", 64'(busy_b), 64'd1);
        present(1'b0, 1'b1, 4'd8, 30'h3FFF5555, 1'b0);
        push_b(8'd0, 32'h5555_5555, cyc + 32'd1);
        present(1'b0, 1'b1, 4'd8, 30'h3FFF5555, 1'b0);
        drain();
        end_session();

        // 16 cycles of 15 atoms 10 -> 15 words, addr 0..14, one per cycle from the 2nd input
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i >= 1) push_b(8'(i - 1), 32'hAAAA_AAAA, cyc + 32'd1);
            present(1'b0, 1'b1, 4'd15, 30'h2AAAAAAA, 1'b0);
        end
        drain();
        end_session();
        check("burst_lost", 64'(lost_b), 64'd0);
        check("burst_full", 64'(full_b), 64'd0);

        // 5 atoms 11 with test_ending in the same cycle -> residual 0x3FF at addr 0
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        push_b(8'd0, 32'h0000_03FF, cyc + 32'd2);
        present(1'b0, 1'b1, 4'd5, 30'h155553FF, 1'b1);
        k = 0;
        while (!ended_b && k < 3) begin
            tick();
            k++;
        end
        check("residual_ended_in_3", 64'(ended_b), 64'd1);
        drain();

        // Arm ignored while busy: a second arm mid-capture must not reset the pointer
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        present(1'b0, 1'b1, 4'd8, 30'h00005555, 1'b0);
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        push_b(8'd0, 32'h5555_5555, cyc + 32'd1);
        present(1'b0, 1'b1, 4'd12, 30'h00555555, 1'b0);
        push_b(8'd1, 32'h0000_0055, cyc + 32'd2);
        end_session();
        drain();

        // Five full words: small RAM either fills (drop 5th) or wraps to addr 0
        mon_s_en = 1'b1;
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1) begin
                push_b(8'(i / 2), 32'h5555_5555, cyc + 32'd1);
`ifdef TRACE_WRAP_EN
                push_s(8'((i / 2) % 4), 32'h5555_5555, cyc + 32'd1);
`else
                if (i / 2 < 4) push_s(8'(i / 2), 32'h5555_5555, cyc + 32'd1);
`endif
            end
            present(1'b0, 1'b1, 4'd8, 30'h3FFF5555, 1'b0);
        end
        drain();
        end_session();
`ifdef TRACE_WRAP_EN
        check("small_full",    64'(full_s),    64'd0);
        check("small_wrapped", 64'(wrapped_s), 64'd1);
        check("small_lost",    64'(lost_s),    64'd0);
`else
        check("small_full",    64'(full_s),    64'd1);
        check("small_wrapped", 64'(wrapped_s), 64'd0);
        check("small_lost",    64'(lost_s),    64'd1);
`endif
        check("big_lost", 64'(lost_b), 64'd0);
        mon_s_en = 1'b0;

        // Reset mid-capture with fill 10: all outputs cleared, no residual write
        present(1'b1, 1'b0, 4'd0, 30'd0, 1'b0);
        present(1'b0, 1'b1, 4'd10, 30'h000FFFFF, 1'b0);
        reset = 1'b1;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        check_reset_outputs("midreset");
        reset = 1'b0;
        repeat (3) tick();

        // test_ending in IDLE -> DONE directly with no write
        present(1'b0, 1'b0, 4'd0, 30'd0, 1'b1);
        check("idle_end_ended", 64'(ended_b), 64'd1);
        check("idle_end_busy",  64'(busy_b),  64'd0);
        repeat (3) tick();
        check("idle_end_no_write", 64'(exp_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
